// File: rtl/mem_stage_bus_pkg.sv
// Shared constants for the MEM-stage bus: peripheral address map and TCON bit layout.
package mem_bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TCON_W = 3;

    localparam logic [DATA_W-1:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [DATA_W-1:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [DATA_W-1:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [DATA_W-1:0] ADDR_LEDS    = 32'h4000_000C;
    localparam logic [DATA_W-1:0] ADDR_DIGITS  = 32'h4000_0010;
    localparam logic [DATA_W-1:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    localparam int unsigned LEDS_W   = 8;
    localparam int unsigned DIGITS_W = 12;

    // Byte address to word-aligned address; low two bits are ignored by the bus.
    function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// MEM-stage load/store bus between the pipeline and the memory/peripheral block.
interface mem_stage_bus_if;
    import mem_bus_pkg::*;

    logic              MEMMemRead;
    logic              MEMMemWrite;
    logic [DATA_W-1:0] MEMALUOut;
    logic [DATA_W-1:0] MEMWrite_data;
    logic [DATA_W-1:0] MEMRead_data;

    modport master (
        output MEMMemRead,
        output MEMMemWrite,
        output MEMALUOut,
        output MEMWrite_data,
        input  MEMRead_data
    );

    modport slave (
        input  MEMMemRead,
        input  MEMMemWrite,
        input  MEMALUOut,
        input  MEMWrite_data,
        output MEMRead_data
    );
endinterface

// File: rtl/mem_stage_bus_timer.sv
// Reloading 32-bit timer: TL counts up from TH, overflow sets the sticky TCON status bit.
module bus_timer
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_th_we,
    input  logic              i_tl_we,
    input  logic              i_tcon_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_th,
    output logic [DATA_W-1:0] o_tl,
    output logic [TCON_W-1:0] o_tcon
);

    logic [DATA_W-1:0] r_th;
    logic [DATA_W-1:0] r_tl;
    logic [TCON_W-1:0] r_tcon;
    logic              w_ovf;

    assign w_ovf = r_tcon[TCON_EN] && (r_tl == '1);

    // Bus writes take priority over the tick for TL and over the overflow set for TCON.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            if (i_th_we) begin
                r_th <= i_wdata;
            end

            if (i_tl_we) begin
                r_tl <= i_wdata;
            end else if (r_tcon[TCON_EN]) begin
                r_tl <= w_ovf ? r_th : r_tl + DATA_W'(1);
            end

            if (i_tcon_we) begin
                r_tcon <= i_wdata[TCON_W-1:0];
            end else if (w_ovf && r_tcon[TCON_IE]) begin
                r_tcon[TCON_IS] <= 1'b1;
            end
        end
    end

    assign o_th   = r_th;
    assign o_tl   = r_tl;
    assign o_tcon = r_tcon;

endmodule

// File: rtl/mem_stage_bus.sv
// MEM-stage data RAM and peripheral bus: address decode, RAM, LEDs, digits, systick, timer.
module mem_stage_bus
    import mem_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned RAM_AW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_stage_bus_if.slave      bus,
    output logic [LEDS_W-1:0]   leds,
    output logic [DIGITS_W-1:0] digits,
    output logic                irq
);

    logic [DATA_W-1:0]   r_ram [RAM_WORDS];
    logic [LEDS_W-1:0]   r_leds;
    logic [DIGITS_W-1:0] r_digits;
    logic [DATA_W-1:0]   r_systick;

    logic [DATA_W-1:0]   w_waddr;
    logic [RAM_AW-1:0]   w_ram_idx;
    logic                w_ram_hit;
    logic [DATA_W-1:0]   w_th;
    logic [DATA_W-1:0]   w_tl;
    logic [TCON_W-1:0]   w_tcon;
    logic [DATA_W-1:0]   w_rdata;

    assign w_waddr   = word_addr(bus.MEMALUOut);
    assign w_ram_idx = bus.MEMALUOut[RAM_AW+1:2];
    assign w_ram_hit = (bus.MEMALUOut[DATA_W-1:RAM_AW+2] == '0);

    bus_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_th_we   (bus.MEMMemWrite && (w_waddr == ADDR_TH)),
        .i_tl_we   (bus.MEMMemWrite && (w_waddr == ADDR_TL)),
        .i_tcon_we (bus.MEMMemWrite && (w_waddr == ADDR_TCON)),
        .i_wdata   (bus.MEMWrite_data),
        .o_th      (w_th),
        .o_tl      (w_tl),
        .o_tcon    (w_tcon)
    );

    // RAM is fully cleared by reset so loads after reset are deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RAM_WORDS); i++) begin
                r_ram[i] <= '0;
            end
        end else if (bus.MEMMemWrite && w_ram_hit) begin
            r_ram[w_ram_idx] <= bus.MEMWrite_data;
        end
    end

    // LED/digit registers; systick free-runs and ignores bus writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds    <= '0;
            r_digits  <= '0;
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + DATA_W'(1);
            if (bus.MEMMemWrite && (w_waddr == ADDR_LEDS)) begin
                r_leds <= bus.MEMWrite_data[LEDS_W-1:0];
            end
            if (bus.MEMMemWrite && (w_waddr == ADDR_DIGITS)) begin
                r_digits <= bus.MEMWrite_data[DIGITS_W-1:0];
            end
        end
    end

    // Load data reflects pre-edge state; zero when idle or unmapped.
    always_comb begin
        w_rdata = '0;
        if (bus.MEMMemRead) begin
            if (w_ram_hit) begin
                w_rdata = r_ram[w_ram_idx];
            end else begin
                case (w_waddr)
                    ADDR_TH:      w_rdata = w_th;
                    ADDR_TL:      w_rdata = w_tl;
                    ADDR_TCON:    w_rdata = DATA_W'(w_tcon);
                    ADDR_LEDS:    w_rdata = DATA_W'(r_leds);
                    ADDR_DIGITS:  w_rdata = DATA_W'(r_digits);
                    ADDR_SYSTICK: w_rdata = r_systick;
                    default:      w_rdata = '0;
                endcase
            end
        end
    end

    assign bus.MEMRead_data = w_rdata;
    assign leds             = r_leds;
    assign digits           = r_digits;
    assign irq              = w_tcon[TCON_IE] & w_tcon[TCON_IS];

endmodule

// File: tb/tb_mem_stage_bus.sv
// Scoreboard bench for mem_stage_bus: directed scenarios then random traffic vs. a behavioural model.
module tb_mem_stage_bus;
    import mem_bus_pkg::*;

    localparam int unsigned RAM_WORDS = 256;
    localparam int unsigned RAM_AW    = 8;
    localparam int unsigned N_RANDOM  = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    mem_stage_bus_if bus ();

    mem_stage_bus #(.RAM_WORDS(RAM_WORDS), .RAM_AW(RAM_AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .leds   (leds),
        .digits (digits),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  leds;
        logic [11:0] digits;
        logic        irq;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // Reference state of the memory map.
    logic [31:0] m_ram [int];
    logic [31:0] m_th, m_tl, m_sys;
    logic [2:0]  m_tcon;
    logic [7:0]  m_leds;
    logic [11:0] m_digits;

    task automatic m_reset();
        m_ram.delete();
        m_th = 0; m_tl = 0; m_sys = 0; m_tcon = 0; m_leds = 0; m_digits = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'(RAM_WORDS * 4)) return m_ram.exists(int'(w / 4)) ? m_ram[int'(w / 4)] : 32'h0;
        if (w == 32'h4000_0000) return m_th;
        if (w == 32'h4000_0004) return m_tl;
        if (w == 32'h4000_0008) return {29'h0, m_tcon};
        if (w == 32'h4000_000C) return {24'h0, m_leds};
        if (w == 32'h4000_0010) return {20'h0, m_digits};
        if (w == 32'h4000_0014) return m_sys;
        return 32'h0;
    endfunction

    // One clock edge of the memory map as seen from the outside.
    task automatic m_step(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w, nth, ntl;
        logic [2:0]  ntcon;
        w = a & 32'hFFFF_FFFC;
        nth = m_th; ntl = m_tl; ntcon = m_tcon;
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                ntl = m_th;
                if (m_tcon[1]) ntcon[2] = 1'b1;
            end else begin
                ntl = m_tl + 1;
            end
        end
        if (wr) begin
            if (w < 32'(RAM_WORDS * 4)) m_ram[int'(w / 4)] = d;
            if (w == 32'h4000_0000) nth = d;
            if (w == 32'h4000_0004) ntl = d;
            if (w == 32'h4000_0008) ntcon = d[2:0];
            if (w == 32'h4000_000C) m_leds = d[7:0];
            if (w == 32'h4000_0010) m_digits = d[11:0];
        end
        m_th = nth; m_tl = ntl; m_tcon = ntcon;
        m_sys = m_sys + 1;
    endtask

    // Drive one bus cycle just after the edge and queue what the DUT should show before the next edge.
    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = rst;
        bus.MEMMemRead    = rd;
        bus.MEMMemWrite   = wr;
        bus.MEMALUOut     = a;
        bus.MEMWrite_data = d;
        if (rst) m_reset();
        e.rdata  = rd ? m_read(a) : 32'h0;
        e.leds   = m_leds;
        e.digits = m_digits;
        e.irq    = m_tcon[1] & m_tcon[2];
        e.id     = n_cyc;
        q.push_back(e);
        n_cyc++;
        if (!rst) m_step(wr, a, d);
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rdata",  e.id, bus.MEMRead_data, e.rdata);
            chk("leds",   e.id, 32'(leds),   32'(e.leds));
            chk("digits", e.id, 32'(digits), 32'(e.digits));
            chk("irq",    e.id, 32'(irq),    32'(e.irq));
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0, 1:    return 32'($urandom_range(0, 15)) * 4 + lo;
            2:       return 32'($urandom_range(0, RAM_WORDS - 1)) * 4 + lo;
            3:       return 32'h4000_0000 + lo;
            4, 5:    return 32'h4000_0004 + lo;
            6:       return 32'h4000_0008 + lo;
            7:       return 32'h4000_000C + lo;
            8:       return 32'h4000_0010 + lo;
            9:       return 32'h4000_0014 + lo;
            10:      return 32'h0000_0400 + 32'($urandom_range(0, 255)) * 4;
            default: return 32'h4000_0018 + 32'($urandom_range(0, 3)) * 4;
        endcase
    endfunction

    initial begin
        logic [31:0] a, d;
        reset = 1'b1;
        bus.MEMMemRead = 0; bus.MEMMemWrite = 0; bus.MEMALUOut = 0; bus.MEMWrite_data = 0;
        m_reset();

        cyc(1, 1, 0, 32'h0, 0);
        cyc(1, 1, 0, ADDR_TCON, 0);
        cyc(0, 1, 0, 32'h0, 0);
        cyc(0, 1, 0, ADDR_TCON, 0);
        cyc(0, 1, 0, ADDR_LEDS, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, ADDR_SYSTICK, 0);

        cyc(0, 0, 1, 32'h10, 32'hDEAD_BEEF);
        cyc(0, 1, 0, 32'h10, 0);
        cyc(0, 1, 0, 32'h400, 0);
        cyc(0, 1, 0, 32'h13, 0);

        cyc(0, 0, 1, ADDR_TH, 32'hFFFF_FFF0);
        cyc(0, 0, 1, ADDR_TL, 32'hFFFF_FFFE);
        cyc(0, 0, 1, ADDR_TCON, 32'h3);
        cyc(0, 1, 0, ADDR_TL, 0);
        cyc(0, 1, 0, ADDR_TL, 0);
        cyc(0, 1, 0, ADDR_TCON, 0);
        cyc(0, 0, 1, ADDR_TCON, 32'h1);
        cyc(0, 1, 0, ADDR_TCON, 0);
        cyc(0, 1, 0, ADDR_TL, 0);

        cyc(0, 0, 1, ADDR_TL, 32'h9);
        cyc(0, 0, 1, ADDR_TL, 32'h5);
        cyc(0, 1, 0, ADDR_TL, 0);

        cyc(0, 1, 1, ADDR_LEDS, 32'hA5);
        cyc(0, 1, 0, ADDR_LEDS, 0);
        cyc(0, 1, 1, ADDR_DIGITS, 32'hFFFF_FABC);
        cyc(0, 0, 1, ADDR_SYSTICK, 32'd123);
        cyc(0, 1, 0, ADDR_SYSTICK, 0);

        cyc(0, 0, 1, ADDR_TCON, 32'h3);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, ADDR_LEDS, 32'h5A);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, ADDR_TL, 0);
        cyc(0, 1, 0, ADDR_TCON, 0);
        cyc(0, 1, 0, ADDR_LEDS, 0);
        cyc(0, 1, 0, ADDR_SYSTICK, 0);
        cyc(0, 1, 0, 32'h10, 0);

        for (int i = 0; i < int'(N_RANDOM); i++) begin
            a = rand_addr();
            d = $urandom;
            if ((a & 32'hFFFF_FFFC) == ADDR_TL && $urandom_range(0, 1) == 1)
                d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ((a & 32'hFFFF_FFFC) == ADDR_TCON && $urandom_range(0, 2) != 0)
                d = 32'($urandom_range(1, 3));
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a, d);
        end
        cyc(0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
